// File: rtl/key_encoder.sv
// Keyboard key-code to serial byte-stream encoder: plain keys pass through,
// arrow keys become ESC-letter pairs. Optional identify reply under KEY_ENCODER_IDENT_EN.
module key_encoder #(
  parameter logic [7:0] ARROW_BASE = 8'h80,
  parameter logic [7:0] IDENT_CHAR = 8'h4B
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       ident_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] SLASH = 8'h2F;
  localparam logic [7:0] LET_A = 8'h41;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SEND1 = 4'b0010,
    SEND2 = 4'b0100,
    SEND3 = 4'b1000
  } state_t;

  state_t     r_state;
  logic [7:0] r_byte2;
  logic [7:0] r_byte3;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;

  logic       w_ident_now;
  logic       w_ident_start;
  logic       w_key_ready;
  logic       w_key_acc;
  logic [7:0] w_off;
  logic       w_is_plain;
  logic       w_is_arrow;

`ifdef KEY_ENCODER_IDENT_EN
  logic r_pend;

  // A fresh pulse counts as pending this cycle so it wins against a simultaneous key.
  assign w_ident_now = r_pend | ident_req;

  always_ff @(posedge clk) begin
    if (clr)
      r_pend <= 1'b0;
    else if (w_ident_start)
      r_pend <= 1'b0;
    else if (ident_req)
      r_pend <= 1'b1;
  end
`else
  logic w_unused_ident;
  assign w_unused_ident = ident_req;
  assign w_ident_now    = 1'b0;
`endif

  assign w_ident_start = (r_state == IDLE) && w_ident_now;
  assign w_key_ready   = (r_state == IDLE) && !w_ident_now && !clr;
  assign w_key_acc     = key_valid && w_key_ready;

  assign w_off      = key_data - ARROW_BASE;
  assign w_is_plain = !key_data[7];
  assign w_is_arrow = key_data[7] && (w_off < 8'd4);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_byte2    <= 8'h00;
      r_byte3    <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ident_start) begin
            r_state    <= SEND1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= ESC;
            r_byte2    <= SLASH;
            r_byte3    <= IDENT_CHAR;
          end else if (w_key_acc) begin
            if (w_is_plain) begin
              r_state    <= SEND3;
              r_tx_valid <= 1'b1;
              r_tx_data  <= key_data;
            end else if (w_is_arrow) begin
              r_state    <= SEND2;
              r_tx_valid <= 1'b1;
              r_tx_data  <= ESC;
              r_byte3    <= LET_A + w_off;
            end
            // any other high code is consumed without output
          end
        end
        SEND1: if (tx_ready) begin
          r_state   <= SEND2;
          r_tx_data <= r_byte2;
        end
        SEND2: if (tx_ready) begin
          r_state   <= SEND3;
          r_tx_data <= r_byte3;
        end
        SEND3: if (tx_ready) begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
          r_tx_data  <= 8'h00;
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
          r_tx_data  <= 8'h00;
        end
      endcase
    end
  end

  assign key_ready = w_key_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: directed scenarios plus a randomized key/backpressure
// run checked against a byte-queue model of the encoding rules.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready;
  logic       ident_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  key_encoder dut (
    .clk      (clk),
    .clr      (clr),
    .key_data (key_data),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .ident_req(ident_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Inputs change just after the rising edge; outputs are read on the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Reference: bytes a key code must produce.
  function automatic void model_key(input logic [7:0] code);
    logic [7:0] l;
    if (code < 8'h80) exp_q.push_back(code);
    else if (code <= 8'h83) begin
      l = code - 8'h80 + 8'h41;
      exp_q.push_back(8'h1B);
      exp_q.push_back(l);
    end
  endfunction

  function automatic void model_ident();
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h2F);
    exp_q.push_back(8'h4B);
  endfunction

  task automatic test_reset;
    clr = 1'b1; key_valid = 1'b0; key_data = 8'h00; ident_req = 1'b0; tx_ready = 1'b1;
    repeat (3) tick;
    sample;
    n_cmp++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL reset_key_ready: got %b want 0", key_ready); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tick; clr = 1'b0;
    sample;
    n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_single;
    tx_ready = 1'b1;
    tick; key_valid = 1'b1; key_data = 8'h41;
    sample;
    n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", key_ready); end
    tick; key_valid = 1'b0;
    sample;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_err++; $display("FAIL single_byte: got v=%b d=%h want v=1 d=41", tx_valid, tx_data); end
    tick;
    sample;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got v=%b want 0", tx_valid); end
    n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_after: got %b want 1", key_ready); end
  endtask

  task automatic test_arrow;
    tx_ready = 1'b1;
    tick; key_valid = 1'b1; key_data = 8'h82;
    sample;
    tick; key_valid = 1'b0;
    sample;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h1B) begin n_err++; $display("FAIL arrow_esc: got v=%b d=%h want v=1 d=1b", tx_valid, tx_data); end
    tick;
    sample;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin n_err++; $display("FAIL arrow_letter: got v=%b d=%h want v=1 d=43", tx_valid, tx_data); end
    n_cmp++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL arrow_busy_ready: got %b want 0", key_ready); end
    tick;
    sample;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL arrow_done: got v=%b want 0", tx_valid); end
  endtask

  task automatic test_stall;
    tick; tx_ready = 1'b0; key_valid = 1'b1; key_data = 8'h81;
    tick; key_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample;
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h1B) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=1b", i, tx_valid, tx_data); end
      tick;
    end
    tx_ready = 1'b1;
    sample;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h1B) begin n_err++; $display("FAIL stall_esc: got v=%b d=%h want v=1 d=1b", tx_valid, tx_data); end
    tick;
    sample;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin n_err++; $display("FAIL stall_letter: got v=%b d=%h want v=1 d=42", tx_valid, tx_data); end
    tick;
    sample;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL stall_done: got v=%b want 0", tx_valid); end
  endtask

  // Covers mid-sequence ident pulses; without identify support they must be ignored.
  task automatic test_ident;
    exp_q.delete(); rx_q.delete();
    tx_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      key_valid = (c == 0); key_data = 8'h80;
      ident_req = (c == 2) || (c == 3);
      sample;
      if (c == 2) begin
        n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL ident_pulse_phase: got d=%h want 41", tx_data); end
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
    end
    ident_req = 1'b0; key_valid = 1'b0;
    model_key(8'h80);
`ifdef KEY_ENCODER_IDENT_EN
    model_ident();
`endif
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL ident_count: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ident_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    sample;
    n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL ident_end_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_priority;
    logic drop;
    exp_q.delete(); rx_q.delete();
    tx_ready = 1'b1; drop = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick;
      if (c == 0) begin key_valid = 1'b1; key_data = 8'h83; end
      if (drop) key_valid = 1'b0;
      ident_req = (c == 0);
      sample;
      if (c == 0) begin
`ifdef KEY_ENCODER_IDENT_EN
        n_cmp++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL prio_key_blocked: got %b want 0", key_ready); end
`else
        n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL prio_key_taken: got %b want 1", key_ready); end
`endif
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (key_valid && key_ready) drop = 1'b1;
    end
    key_valid = 1'b0; ident_req = 1'b0;
`ifdef KEY_ENCODER_IDENT_EN
    model_ident();
`endif
    model_key(8'h83);
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL prio_count: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL prio_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_clr;
    tx_ready = 1'b1;
    tick; key_valid = 1'b1; key_data = 8'h80;
    sample;
    tick; key_valid = 1'b0;
    sample;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h1B) begin n_err++; $display("FAIL clr_esc: got v=%b d=%h want v=1 d=1b", tx_valid, tx_data); end
    tick; tx_ready = 1'b0; clr = 1'b1;
    sample;
    n_cmp++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready_low: got %b want 0", key_ready); end
    tick; clr = 1'b0; tx_ready = 1'b1;
    sample;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL clr_abort: got v=%b want 0", tx_valid); end
    n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready_after: got %b want 1", key_ready); end
    tick; key_valid = 1'b1; key_data = 8'hFF;
    sample;
    n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL clr_ff_ready: got %b want 1", key_ready); end
    for (int i = 0; i < 4; i++) begin
      tick; key_valid = 1'b0;
      sample;
      n_cmp++; if (tx_valid !== 1'b0 || key_ready !== 1'b1) begin n_err++; $display("FAIL clr_ff_silent[%0d]: got v=%b r=%b want v=0 r=1", i, tx_valid, key_ready); end
    end
    // ident pulse coinciding with clr must vanish
    tick; clr = 1'b1; ident_req = 1'b1;
    tick; clr = 1'b0; ident_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample;
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL clr_ident_drop[%0d]: got v=%b want 0", i, tx_valid); end
      tick;
    end
  endtask

  task automatic test_random;
    logic acc;
    int   r;
    exp_q.delete();
    acc = 1'b1;
    for (int c = 0; c < 420; c++) begin
      tick;
      if (c >= 400) begin
        key_valid = 1'b0; tx_ready = 1'b1;
      end else begin
        if (acc || !key_valid) begin
          key_valid = ($urandom_range(0, 2) != 0);
          r = $urandom_range(0, 2);
          case (r)
            0:       key_data = 8'($urandom_range(0, 127));
            1:       key_data = 8'(8'h80 + $urandom_range(0, 3));
            default: key_data = 8'($urandom_range(132, 255));
          endcase
        end
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      sample;
      n_cmp++; if (key_ready !== (exp_q.size() == 0)) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, key_ready, exp_q.size() == 0); end
      n_cmp++; if (tx_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rand_valid c%0d: got %b want %b", c, tx_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_cmp++; if (tx_data !== exp_q[0]) begin n_err++; $display("FAIL rand_data c%0d: got %h want %h", c, tx_data, exp_q[0]); end
      end
      if (tx_valid && tx_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      acc = key_valid && key_ready;
      if (acc) model_key(key_data);
    end
    key_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_arrow;
    test_stall;
    test_ident;
    test_priority;
    test_clr;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
